plot_sequencer: RTL and testbench
=================================

PLOT_SEQUENCER -- requirements
Module: plot_sequencer

Interface
REQ-001 Parameter NUM_PLAYERS, 4, number of player channels; legal range 1..8.
REQ-002 Parameter PALETTE, {3'b110,3'b100,3'b010,3'b001}, packed 3-bit colour per player; player i uses bits [3i+2:3i].
REQ-003 Parameter TIMER_COLOUR, 3'b111, colour of the timer-bar pixel.
REQ-004 Parameter TIMER_ROW, 7'd119, y coordinate of the timer bar.
REQ-005 Parameter TIMER_LEN, 8'd158, final timer_x value; legal range 1..159.
REQ-006 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  single-cycle pulse; begins or restarts a round.
REQ-009 timer_tick  input  1  single-cycle enable pulse, synchronous to CLOCK_50; advances the timer bar.
REQ-010 p_pos  input  15*NUM_PLAYERS  packed positions; player i is {x[7:0], y[6:0]} at bits [15i+14:15i].
REQ-011 p_en  input  NUM_PLAYERS  per-player draw enable.
REQ-012 plot_ready  input  1  pixel sink accepts the current pixel.
REQ-013 x  output  8  pixel x.
REQ-014 y  output  7  pixel y.
REQ-015 colour  output  3  pixel colour.
REQ-016 plot  output  1  pixel valid.
REQ-017 running  output  1  round in progress.
REQ-018 timer_x  output  8  current timer-bar column.
REQ-019 done  output  1  single-cycle pulse at round end.

Function
REQ-020 The FSM SHALL use states IDLE, PLAYER, TIMER and FINISHED.
REQ-021 A pixel SHALL transfer on any rising edge where plot and plot_ready are both 1; x, y and colour SHALL hold stable while plot=1 and plot_ready=0.
REQ-022 All outputs SHALL be registered; with plot_ready held at 1, one pixel SHALL transfer per cycle with no bubbles.
REQ-023 IDLE: plot=0; start moves the FSM to PLAYER (or to TIMER if p_en=0), sets running=1 and clears timer_x to 0.
REQ-024 Slot order SHALL be enabled players in ascending index, then one TIMER slot, then repeat.
REQ-025 Disabled players SHALL be skipped without spending a cycle; p_en SHALL be sampled when the next slot is selected.
REQ-026 A player slot SHALL present p_pos[i] as sampled at load, with colour PALETTE[i].
REQ-027 A TIMER slot SHALL present x=timer_x, y=TIMER_ROW and colour=TIMER_COLOUR.
REQ-028 timer_tick SHALL increment timer_x by 1 only while running=1; timer_tick SHALL be ignored in IDLE and FINISHED.
REQ-029 A timer_tick that arrives while timer_x==TIMER_LEN SHALL clear running, pulse done for one cycle and leave timer_x at TIMER_LEN.
REQ-030 If a pixel is pending when running clears, it SHALL complete its transfer; the FSM SHALL then enter FINISHED with plot=0.
REQ-031 FINISHED SHALL hold until start, which behaves as in REQ-023.
REQ-032 start while running SHALL abort the pending pixel, clear timer_x and restart from the first enabled slot.
REQ-033 When start and timer_tick occur in the same cycle, start SHALL win and the tick SHALL be discarded.
REQ-034 A tick coinciding with a transfer SHALL take effect; the next TIMER slot SHALL show the incremented value.

Reset
REQ-035 resetn=0 SHALL immediately force IDLE, plot=0, running=0, done=0, timer_x=0, x=0, y=0 and colour=0, including mid-operation.

Verification
REQ-036 Reset, start, p_en=4'b1111, plot_ready=1 -> the repeating colour sequence 001,010,100,110,111 appears, one pixel per cycle.
REQ-037 p_en=4'b0101 -> the sequence is p0, p2, timer; no dead cycles.
REQ-038 plot_ready=0 for 5 cycles during the p1 slot -> x, y and colour stay stable, and the p1 pixel transfers when plot_ready returns to 1.
REQ-039 TIMER_LEN=3, then 4 ticks -> timer_x runs 1,2,3; the 4th tick pulses done and clears running; plot=0 after the final transfer.
REQ-040 start and timer_tick in the same cycle at timer_x=2 -> timer_x=0 and running=1.
REQ-041 resetn pulsed low while plot=1 -> all outputs go to 0 asynchronously, the FSM is in IDLE, and there is no activity until start.

Source files
------------

// File: rtl/plot_sequencer_if.sv
// Pixel bus between the plot sequencer and a pixel sink (e.g. a VGA adapter).
// A pixel moves on any rising clock edge where plot and plot_ready are both 1.
interface plot_sequencer_if;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       plot_ready;

    modport master (
        output x,
        output y,
        output colour,
        output plot,
        input  plot_ready
    );

    modport slave (
        input  x,
        input  y,
        input  colour,
        input  plot,
        output plot_ready
    );
endinterface

// File: rtl/plot_sequencer.sv
// Plot sequencer: during a round it walks the enabled players in ascending
// index order and then one timer-bar slot, and repeats. Each slot presents
// one pixel on the pixel bus. timer_tick advances the timer bar. The round
// ends when a tick arrives with the bar already at TIMER_LEN.
module plot_sequencer #(
    parameter int                         NUM_PLAYERS  = 4,
    parameter logic [3*NUM_PLAYERS-1:0]   PALETTE      = {3'b110, 3'b100, 3'b010, 3'b001},
    parameter logic [2:0]                 TIMER_COLOUR = 3'b111,
    parameter logic [6:0]                 TIMER_ROW    = 7'd119,
    parameter logic [7:0]                 TIMER_LEN    = 8'd158
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         timer_tick,
    input  logic [15*NUM_PLAYERS-1:0]    p_pos,
    input  logic [NUM_PLAYERS-1:0]       p_en,
    plot_sequencer_if.master             bus,
    output logic                         running,
    output logic [7:0]                   timer_x,
    output logic                         done
);

    localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAYER   = 2'd1,
        TIMER    = 2'd2,
        FINISHED = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   slot_reg, slot_next;
    logic [7:0]         x_reg, x_next;
    logic [6:0]         y_reg, y_next;
    logic [2:0]         colour_reg, colour_next;
    logic               plot_reg, plot_next;
    logic               running_reg, running_next;
    logic [7:0]         timer_reg, timer_next;
    logic               done_reg, done_next;

    // Per-player coordinates and colours, unpacked from the flat buses.
    logic [7:0]         pos_x  [NUM_PLAYERS];
    logic [6:0]         pos_y  [NUM_PLAYERS];
    logic [2:0]         pal    [NUM_PLAYERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_unpack
            assign pos_x[gi] = p_pos[15*gi+14 : 15*gi+7];
            assign pos_y[gi] = p_pos[15*gi+6  : 15*gi];
            assign pal[gi]   = PALETTE[3*gi+2 : 3*gi];
        end
    endgenerate

    // Slot search results, taken from p_en as it is right now.
    logic               first_found;
    logic [IDX_W-1:0]   first_idx;
    logic               after_found;
    logic [IDX_W-1:0]   after_idx;

    // Find the lowest enabled player, and the lowest enabled one above the current slot.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        after_found = 1'b0;
        after_idx   = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (p_en[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (p_en[i] && (i > int'(slot_reg))) begin
                after_found = 1'b1;
                after_idx   = IDX_W'(i);
            end
        end
    end

    // Round bookkeeping: start restarts everything and swallows a same-cycle tick.
    always_comb begin
        running_next = running_reg;
        timer_next   = timer_reg;
        done_next    = 1'b0;
        if (start) begin
            running_next = 1'b1;
            timer_next   = 8'd0;
        end else if (running_reg && timer_tick) begin
            if (timer_reg == TIMER_LEN) begin
                running_next = 1'b0;
                done_next    = 1'b1;
            end else begin
                timer_next = timer_reg + 8'd1;
            end
        end
    end

    // Slot FSM: picks the next slot on start or on a completed transfer and loads its pixel.
    always_comb begin
        logic             load_player;
        logic             load_timer;
        logic [IDX_W-1:0] load_idx;

        state_next  = state_reg;
        slot_next   = slot_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        colour_next = colour_reg;
        plot_next   = plot_reg;
        load_player = 1'b0;
        load_timer  = 1'b0;
        load_idx    = first_idx;

        case (state_reg)
            IDLE, FINISHED: begin
                plot_next = 1'b0;
                if (start) begin
                    load_player = first_found;
                    load_timer  = !first_found;
                end
            end
            PLAYER, TIMER: begin
                if (start) begin
                    // Drop whatever is pending and begin again from the first slot.
                    load_player = first_found;
                    load_timer  = !first_found;
                end else if (bus.plot_ready) begin
                    if (!running_next) begin
                        // Last pixel of the round has just gone out.
                        state_next = FINISHED;
                        plot_next  = 1'b0;
                    end else if (state_reg == PLAYER) begin
                        load_player = after_found;
                        load_timer  = !after_found;
                        load_idx    = after_idx;
                    end else begin
                        load_player = first_found;
                        load_timer  = !first_found;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                plot_next  = 1'b0;
            end
        endcase

        if (load_player) begin
            state_next  = PLAYER;
            slot_next   = load_idx;
            x_next      = pos_x[load_idx];
            y_next      = pos_y[load_idx];
            colour_next = pal[load_idx];
            plot_next   = 1'b1;
        end else if (load_timer) begin
            // Uses the post-tick value so a tick landing on this edge shows up.
            state_next  = TIMER;
            x_next      = timer_next;
            y_next      = TIMER_ROW;
            colour_next = TIMER_COLOUR;
            plot_next   = 1'b1;
        end
    end

    // State and output registers, cleared immediately by resetn.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            slot_reg    <= '0;
            x_reg       <= 8'd0;
            y_reg       <= 7'd0;
            colour_reg  <= 3'd0;
            plot_reg    <= 1'b0;
            running_reg <= 1'b0;
            timer_reg   <= 8'd0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            slot_reg    <= slot_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            colour_reg  <= colour_next;
            plot_reg    <= plot_next;
            running_reg <= running_next;
            timer_reg   <= timer_next;
            done_reg    <= done_next;
        end
    end

    assign bus.x      = x_reg;
    assign bus.y      = y_reg;
    assign bus.colour = colour_reg;
    assign bus.plot   = plot_reg;
    assign running    = running_reg;
    assign timer_x    = timer_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_plot_sequencer.sv
// Bench for plot_sequencer: a slot-list reference model predicts every
// cycle's outputs; directed scenarios add checks against fixed constants.
module tb_plot_sequencer;

    localparam int         N    = 4;
    localparam logic [7:0] LEN  = 8'd3;
    localparam logic [6:0] TROW = 7'd119;
    localparam logic [2:0] TCOL = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic              start;
    logic              timer_tick;
    logic [15*N-1:0]   p_pos;
    logic [N-1:0]      p_en;
    logic              running;
    logic [7:0]        timer_x;
    logic              done;

    plot_sequencer_if bus();

    plot_sequencer #(.NUM_PLAYERS(N), .TIMER_LEN(LEN)) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .start      (start),
        .timer_tick (timer_tick),
        .p_pos      (p_pos),
        .p_en       (p_en),
        .bus        (bus),
        .running    (running),
        .timer_x    (timer_x),
        .done       (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] pal_tab [N] = '{3'b001, 3'b010, 3'b100, 3'b110};

    // Reference model state
    bit         m_run, m_pend, m_done;
    logic [7:0] m_timer;
    int         m_slot;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;

    // Slot list = enabled players ascending, then the timer slot (N).
    function automatic int next_slot(int cur);
        int q[$];
        for (int i = 0; i < N; i++) if (p_en[i]) q.push_back(i);
        q.push_back(N);
        foreach (q[k]) if (q[k] > cur) return q[k];
        return q[0];
    endfunction

    task automatic model_load(int s);
        m_slot = s;
        if (s == N) begin
            m_x = m_timer; m_y = TROW; m_c = TCOL;
        end else begin
            m_x = p_pos[15*s+7 +: 8];
            m_y = p_pos[15*s +: 7];
            m_c = pal_tab[s];
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_done = 0; m_timer = 8'd0; m_slot = -1;
        m_x = 8'd0; m_y = 7'd0; m_c = 3'd0;
    endtask

    task automatic model_edge(input logic s, input logic t, input logic r);
        bit xfer;
        m_done = 0;
        if (s) begin
            m_run = 1; m_timer = 8'd0; m_pend = 1;
            model_load(next_slot(-1));
        end else begin
            xfer = m_pend && r;
            if (m_run && t) begin
                if (m_timer == LEN) begin m_run = 0; m_done = 1; end
                else m_timer = m_timer + 8'd1;
            end
            if (xfer) begin
                if (!m_run) m_pend = 0;
                else model_load(next_slot(m_slot));
            end
        end
    endtask

    function automatic logic [28:0] obs_vec();
        return {bus.plot, bus.plot ? bus.x : 8'h0, bus.plot ? bus.y : 7'h0,
                bus.plot ? bus.colour : 3'h0, running, timer_x, done};
    endfunction

    function automatic logic [28:0] exp_vec();
        return {m_pend, m_pend ? m_x : 8'h0, m_pend ? m_y : 7'h0,
                m_pend ? m_c : 3'h0, m_run, m_timer, m_done};
    endfunction

    // Drive one cycle's inputs (called at a falling edge), advance the model, wait one cycle.
    task automatic cyc(input logic s, input logic t, input logic r);
        start = s; timer_tick = t; bus.plot_ready = r;
        model_edge(s, t, r);
        @(negedge clk);
        start = 1'b0; timer_tick = 1'b0;
    endtask

    task automatic rand_pos();
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        p_pos = r64[15*N-1:0];
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; timer_tick = 1'b0; bus.plot_ready = 1'b0;
        p_en = 4'b1111; rand_pos();
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.plot, bus.x, bus.y, bus.colour, running, timer_x, done} !== 29'h0) begin
            n_bad++;
            $display("FAIL reset_state got %h want 0",
                     {bus.plot, bus.x, bus.y, bus.colour, running, timer_x, done});
        end
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL idle_no_start got %h want %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_all_enabled();
        logic [2:0] seq [5] = '{3'b001, 3'b010, 3'b100, 3'b110, 3'b111};
        p_en = 4'b1111; rand_pos();
        cyc(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (bus.plot !== 1'b1 || bus.colour !== seq[k%5]) begin
                n_bad++;
                $display("FAIL all_en_seq k=%0d got plot=%b colour=%b want plot=1 colour=%b",
                         k, bus.plot, bus.colour, seq[k%5]);
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL all_en_model k=%0d got %h want %h", k, obs_vec(), exp_vec());
            end
            cyc(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_skip();
        logic [2:0] seq [3] = '{3'b001, 3'b100, 3'b111};
        p_en = 4'b0101; rand_pos();
        cyc(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (bus.plot !== 1'b1 || bus.colour !== seq[k%3]) begin
                n_bad++;
                $display("FAIL skip_seq k=%0d got plot=%b colour=%b want plot=1 colour=%b",
                         k, bus.plot, bus.colour, seq[k%3]);
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL skip_model k=%0d got %h want %h", k, obs_vec(), exp_vec());
            end
            cyc(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_stall();
        logic [7:0] hx;
        logic [6:0] hy;
        logic [2:0] hc;
        bit found;
        p_en = 4'b1111; rand_pos();
        cyc(1'b1, 1'b0, 1'b1);
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (bus.plot === 1'b1 && bus.colour === 3'b010) found = 1;
            else cyc(1'b0, 1'b0, 1'b1);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL stall_find_p1 got colour=%b want 010 within 12 cycles", bus.colour);
        end
        hx = bus.x; hy = bus.y; hc = bus.colour;
        for (int k = 0; k < 5; k++) begin
            rand_pos();
            cyc(1'b0, (k == 2), 1'b0);
            n_cmp++;
            if ({bus.plot, bus.x, bus.y, bus.colour} !== {1'b1, hx, hy, hc}) begin
                n_bad++;
                $display("FAIL stall_hold k=%0d got %h want %h", k,
                         {bus.plot, bus.x, bus.y, bus.colour}, {1'b1, hx, hy, hc});
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stall_model k=%0d got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        cyc(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.plot !== 1'b1 || bus.colour !== 3'b100) begin
            n_bad++;
            $display("FAIL stall_release got plot=%b colour=%b want plot=1 colour=100",
                     bus.plot, bus.colour);
        end
    endtask

    task automatic test_timer_end();
        p_en = 4'($urandom_range(0, 15)); rand_pos();
        cyc(1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (k < 4) begin
                if ({timer_x, running, done} !== {8'(k), 1'b1, 1'b0}) begin
                    n_bad++;
                    $display("FAIL timer_step k=%0d got timer_x=%0d running=%b done=%b want %0d,1,0",
                             k, timer_x, running, done, k);
                end
            end else begin
                if ({timer_x, running, done, bus.plot} !== {LEN, 1'b0, 1'b1, 1'b0}) begin
                    n_bad++;
                    $display("FAIL timer_end got timer_x=%0d running=%b done=%b plot=%b want 3,0,1,0",
                             timer_x, running, done, bus.plot);
                end
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL timer_model k=%0d got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        cyc(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({timer_x, running, done, bus.plot} !== {LEN, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL finished_hold got timer_x=%0d running=%b done=%b plot=%b want 3,0,0,0",
                     timer_x, running, done, bus.plot);
        end
    endtask

    task automatic test_start_tick();
        p_en = 4'b1010; rand_pos();
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (timer_x !== 8'd2) begin
            n_bad++;
            $display("FAIL start_tick_pre got timer_x=%0d want 2", timer_x);
        end
        cyc(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if ({timer_x, running, done, bus.plot, bus.colour} !== {8'd0, 1'b1, 1'b0, 1'b1, 3'b010}) begin
            n_bad++;
            $display("FAIL start_tick got timer_x=%0d running=%b done=%b plot=%b colour=%b want 0,1,0,1,010",
                     timer_x, running, done, bus.plot, bus.colour);
        end
    endtask

    task automatic test_async_reset();
        p_en = 4'b1111; rand_pos();
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (bus.plot !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_pre got plot=%b want 1", bus.plot);
        end
        #1 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.plot, bus.x, bus.y, bus.colour, running, timer_x, done} !== 29'h0) begin
            n_bad++;
            $display("FAIL areset_async got %h want 0",
                     {bus.plot, bus.x, bus.y, bus.colour, running, timer_x, done});
        end
        @(negedge clk);
        model_reset();
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL areset_quiet k=%0d got %h want %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic s, t, r;
        for (int k = 0; k < 800; k++) begin
            rand_pos();
            if ($urandom_range(0, 9) == 0) p_en = 4'($urandom_range(0, 15));
            s = ($urandom_range(0, 49) == 0) || (!m_run && !m_pend && $urandom_range(0, 4) == 0);
            t = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
            cyc(s, t, r);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random k=%0d got %h want %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; timer_tick = 1'b0; bus.plot_ready = 1'b0;
        p_en = '0; p_pos = '0;
        @(negedge clk);
        test_reset();
        test_all_enabled();
        test_skip();
        test_stall();
        test_timer_end();
        test_start_tick();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
